// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_pkg;

   localparam int REG_W       = 5;
   localparam int DEF_TIMEOUT = 16;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / memory-wait hazard sequencer for the 5-stage MIPS pipeline.
// Stall performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_EX_MemRead,
   input  logic [REG_W-1:0] ID_EX_RegisterRt,
   input  logic [REG_W-1:0] IF_ID_RegisterRs,
   input  logic [REG_W-1:0] IF_ID_RegisterRt,
   input  logic             IF_ID_UsesRt,
   input  logic             Branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_Flush,
   output logic             ID_Flush_lwstall,
   output logic             Pipe_Hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt
);

   localparam int WC_W = $clog2(TIMEOUT + 1);

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            mem_timeout_nxt;
   logic            mw, lu;

   assign mw = dmem_req & ~dmem_ready;
   assign lu = ID_EX_MemRead & (ID_EX_RegisterRt != '0) &
               ((ID_EX_RegisterRt == IF_ID_RegisterRs) |
                (IF_ID_UsesRt & (ID_EX_RegisterRt == IF_ID_RegisterRt)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= mem_timeout_nxt;
      end
   end

   // Priority: fault, then memory wait, then load-use, then branch redirect.
   always_comb begin
      state_nxt        = state;
      wait_cnt_nxt     = wait_cnt;
      mem_timeout_nxt  = mem_timeout;
      PC_Write         = 1'b1;
      IF_ID_Write      = 1'b1;
      IF_Flush         = 1'b0;
      ID_Flush_lwstall = 1'b0;
      Pipe_Hold        = 1'b0;
      if (reset) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
      end else if (state == FAULT) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         Pipe_Hold   = 1'b1;
      end else if (mw) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         Pipe_Hold   = 1'b1;
         if (state == RUN) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = WC_W'(1);
         end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
            state_nxt       = FAULT;
            mem_timeout_nxt = 1'b1;
         end else begin
            wait_cnt_nxt = wait_cnt + WC_W'(1);
         end
      end else begin
         state_nxt    = RUN;
         wait_cnt_nxt = '0;
         if (lu) begin
            PC_Write         = 1'b0;
            IF_ID_Write      = 1'b0;
            ID_Flush_lwstall = 1'b1;
         end else if (Branch_taken) begin
            IF_Flush = 1'b1;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic mem_inc;
   assign mem_inc = Pipe_Hold & (state != FAULT);

   sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (ID_Flush_lwstall),
      .count (lu_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mem_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mem_inc),
      .count (mem_stall_cnt)
   );
`else
   assign lu_stall_cnt  = '0;
   assign mem_stall_cnt = '0;
`endif

endmodule
